// File: rtl/md_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// md_scheduler_pkg
//
// Shared definitions for the multiply/divide scheduler:
//   - md_op_e    : md_op encodings (mult, multu, div, divu)
//   - md_state_e : scheduler states (IDLE, RUN)
//   - MD_MUL_LAT / MD_DIV_LAT : cycles spent in RUN per operation class
//   - op_latency(): picks the latency for a given operation
// ---------------------------------------------------------------------------
package md_scheduler_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam logic [3:0] MD_MUL_LAT = 4'd5;
    localparam logic [3:0] MD_DIV_LAT = 4'd10;

    // Both divide encodings have bit 1 set.
    function automatic logic is_div(input md_op_e op);
        return op[1];
    endfunction

    function automatic logic [3:0] op_latency(input md_op_e op);
        return is_div(op) ? MD_DIV_LAT : MD_MUL_LAT;
    endfunction

endpackage

// File: rtl/md_arith.sv
// ---------------------------------------------------------------------------
// md_arith
//
// Purely combinational datapath for the multiply/divide unit. Works on the
// operands latched by md_scheduler and produces the HI/LO values to be
// written when the operation completes.
//
// Ports:
//   op      in  [1:0]  operation (md_op_e encoding)
//   a       in  [31:0] multiplicand / dividend
//   b       in  [31:0] multiplier / divisor
//   res_hi  out [31:0] product[63:32] or remainder
//   res_lo  out [31:0] product[31:0]  or quotient
//   res_wr  out        0 when the result must not be written (divide by zero)
// ---------------------------------------------------------------------------
module md_arith
    import md_scheduler_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        res_wr
);

    md_op_e      op_e;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic        signed_div;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_den;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign op_e = md_op_e'(op);

    // Multiply: sign- or zero-extend both operands to 64 bits; the low 64
    // bits of the 64x64 product are then the correct two's-complement
    // product for both the signed and unsigned cases.
    always_comb begin
        ext_a = (op_e == MD_MULT) ? {{32{a[31]}}, a} : {32'd0, a};
        ext_b = (op_e == MD_MULT) ? {{32{b[31]}}, b} : {32'd0, b};
        prod  = ext_a * ext_b;
    end

    // Divide: run an unsigned divide on magnitudes and fix the signs after.
    // The quotient is negative when operand signs differ, the remainder
    // follows the dividend. 0x80000000 / -1 falls out naturally: its
    // magnitude is 0x80000000, both signs are negative, so the quotient is
    // 0x80000000 and the remainder 0. A zero divisor is swapped for 1 only
    // to keep the divider well defined; its result is never written.
    always_comb begin
        signed_div = (op_e == MD_DIV);
        neg_a      = signed_div & a[31];
        neg_b      = signed_div & b[31];
        mag_a      = neg_a ? (32'd0 - a) : a;
        mag_b      = neg_b ? (32'd0 - b) : b;
        div_den    = (b == 32'd0) ? 32'd1 : mag_b;
        q_mag      = mag_a / div_den;
        r_mag      = mag_a % div_den;
        quot       = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
        rem        = neg_a ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        res_wr = 1'b1;
        if (is_div(op_e)) begin
            res_hi = rem;
            res_lo = quot;
            res_wr = (b != 32'd0);
        end
    end

endmodule

// File: rtl/md_scheduler.sv
// ---------------------------------------------------------------------------
// md_scheduler
//
// Sequencer for the MIPS-style multiply/divide unit. Accepts an E-stage
// mult/multu/div/divu, holds busy for a fixed latency, then writes HI/LO.
// Also handles mthi/mtlo and raises the D-stage stall request.
//
// Ports:
//   clk       in         clock, rising edge
//   reset_n   in         asynchronous active-low reset
//   start     in         E-stage multiply/divide valid
//   md_op     in  [1:0]  00 mult, 01 multu, 10 div, 11 divu
//   rs_val    in  [31:0] first operand / mthi-mtlo data
//   rt_val    in  [31:0] second operand
//   moveto    in  [1:0]  [1] mthi, [0] mtlo
//   md_use_D  in         D-stage instruction uses the unit
//   flush     in         exception/eret: drop this cycle's start/move
//   busy      out        operation in progress
//   md_stall  out        combinational stall to the D stage
//   hi, lo    out [31:0] architectural HI/LO registers
// ---------------------------------------------------------------------------
module md_scheduler
    import md_scheduler_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [1:0]  moveto,
    input  logic        md_use_D,
    input  logic        flush,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [1:0]  op_q,    op_d;
    logic [31:0] a_q,     a_d;
    logic [31:0] b_q,     b_d;
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;

    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_wr;

    md_arith u_arith (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .res_wr (res_wr)
    );

    // Next-state logic. In IDLE a start wins over a move in the same cycle
    // and flush suppresses both. In RUN every new request is ignored and
    // flush has no effect, so an accepted operation always runs to the end.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    op_d    = md_op;
                    a_d     = rs_val;
                    b_d     = rt_val;
                    cnt_d   = op_latency(md_op_e'(md_op));
                    state_d = ST_RUN;
                end else if ((moveto != 2'b00) && !flush) begin
                    if (moveto[1]) hi_d = rs_val;
                    if (moveto[0]) lo_d = rs_val;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - 4'd1;
                // Result lands on the same edge that drops busy.
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                    if (res_wr) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 2'b00;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign md_stall = md_use_D & (start | busy);
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_md_scheduler.sv
// ---------------------------------------------------------------------------
// tb_md_scheduler
//
// Self-checking bench for md_scheduler. The stimulus process drives one
// request per cycle and keeps a behavioural model of HI/LO and the remaining
// busy time; every accepted operation pushes its expected result and latency
// into a scoreboard queue. A monitor process pops that queue whenever busy
// falls and compares the DUT's hi/lo and the measured busy length.
// ---------------------------------------------------------------------------
module tb_md_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [1:0]  moveto;
    logic        md_use_D;
    logic        flush;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          vectors     = 0;
    int          miscompares = 0;

    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;
    logic [31:0] pend_hi = 32'd0;
    logic [31:0] pend_lo = 32'd0;
    logic        pend_wr = 1'b0;
    int          run_left = 0;

    always #5 clk = ~clk;

    md_scheduler dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .moveto   (moveto),
        .md_use_D (md_use_D),
        .flush    (flush),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic written straight from the instruction definitions.
    function automatic void refResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic wr, output logic [31:0] rh, output logic [31:0] rl,
                                      output int lat);
        longint          p;
        longint unsigned pu;
        int              sa;
        int              sb;
        int              q;
        int              r;
        wr = 1'b1;
        rh = 32'd0;
        rl = 32'd0;
        sa = a;
        sb = b;
        case (op)
            2'b00: begin
                p = longint'(sa) * longint'(sb);
                {rh, rl} = p;
                lat = 5;
            end
            2'b01: begin
                pu = longint'(a) * longint'(b);
                {rh, rl} = pu;
                lat = 5;
            end
            2'b10: begin
                lat = 10;
                if (b == 32'd0) begin
                    wr = 1'b0;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    rl = 32'h8000_0000;
                    rh = 32'd0;
                end else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    rl = q;
                    rh = r;
                end
            end
            default: begin
                lat = 10;
                if (b == 32'd0) begin
                    wr = 1'b0;
                end else begin
                    rl = a / b;
                    rh = a % b;
                end
            end
        endcase
    endfunction

    // Drives one cycle of inputs (called at posedge+1), checks the stall,
    // advances the model across the edge, then checks busy/hi/lo.
    task automatic applyStimulus(input logic st, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [1:0] mv, input logic fl,
                                 input logic use_d);
        logic        wr;
        logic [31:0] rh;
        logic [31:0] rl;
        int          lat;
        bit          idle;
        idle     = (run_left == 0);
        start    = st;
        md_op    = op;
        rs_val   = a;
        rt_val   = b;
        moveto   = mv;
        flush    = fl;
        md_use_D = use_d;
        #1;
        checkOutput("md_stall", 32'(md_stall), 32'(use_d & (st | !idle)));
        @(posedge clk);
        if (!idle) begin
            run_left--;
            if (run_left == 0 && pend_wr) begin
                hi_m = pend_hi;
                lo_m = pend_lo;
            end
        end else if (st && !fl) begin
            refResult(op, a, b, wr, rh, rl, lat);
            pend_wr  = wr;
            pend_hi  = rh;
            pend_lo  = rl;
            run_left = lat;
            sb_q.push_back('{hi: wr ? rh : hi_m, lo: wr ? rl : lo_m, lat: lat});
        end else if (!fl && mv != 2'b00) begin
            if (mv[1]) hi_m = a;
            if (mv[0]) lo_m = a;
        end
        #1;
        start  = 1'b0;
        moveto = 2'b00;
        flush  = 1'b0;
        checkOutput("busy", 32'(busy), 32'(run_left > 0));
        checkOutput("hi", hi, hi_m);
        checkOutput("lo", lo, lo_m);
    endtask

    task automatic idleCycles(input int n, input logic use_d);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 2'b00, 1'b0, use_d);
    endtask

    // Pulses reset for one edge; outputs must clear before any clock edge.
    task automatic doReset(input logic st, input logic use_d);
        start    = st;
        md_use_D = use_d;
        reset_n  = 1'b0;
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_hi", hi, 32'd0);
        checkOutput("rst_lo", lo, 32'd0);
        checkOutput("rst_stall", 32'(md_stall), 32'(use_d & st));
        hi_m     = 32'd0;
        lo_m     = 32'd0;
        pend_wr  = 1'b0;
        run_left = 0;
        sb_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        start   = 1'b0;
        checkOutput("rst_busy_after_edge", 32'(busy), 32'd0);
    endtask

    // Monitor: busy falling marks a completed operation.
    initial begin : monitor
        bit   prev_busy;
        int   busy_len;
        exp_t e;
        prev_busy = 1'b0;
        busy_len  = 0;
        forever begin
            @(negedge clk);
            if (reset_n !== 1'b1) begin
                prev_busy = 1'b0;
                busy_len  = 0;
            end else begin
                if (busy === 1'b1) begin
                    busy_len++;
                end else if (prev_busy) begin
                    if (sb_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL sb_unexpected: got completion, expected none at %0t", $time);
                    end else begin
                        e = sb_q.pop_front();
                        checkOutput("sb_hi", hi, e.hi);
                        checkOutput("sb_lo", lo, e.lo);
                        checkOutput("sb_latency", busy_len, e.lat);
                    end
                    busy_len = 0;
                end
                prev_busy = (busy === 1'b1);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        logic        st;
        logic        fl;
        logic        use_d;
        logic [1:0]  op;
        logic [1:0]  mv;
        logic [31:0] a;
        logic [31:0] b;

        reset_n  = 1'b0;
        start    = 1'b0;
        md_op    = 2'b00;
        rs_val   = 32'd0;
        rt_val   = 32'd0;
        moveto   = 2'b00;
        md_use_D = 1'b0;
        flush    = 1'b0;
        @(posedge clk);
        #1;
        doReset(1'b1, 1'b1);
        $display("[TB] reset checked");

        // Signed multiply -2 * 3.
        applyStimulus(1'b1, 2'b00, 32'hFFFF_FFFE, 32'd3, 2'b00, 1'b0, 1'b0);
        idleCycles(5, 1'b0);
        checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
        checkOutput("mult_lo", lo, 32'hFFFF_FFFA);

        // Unsigned multiply of all-ones.
        applyStimulus(1'b1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1'b0, 1'b0);
        idleCycles(5, 1'b0);
        checkOutput("multu_hi", hi, 32'hFFFF_FFFE);
        checkOutput("multu_lo", lo, 32'h0000_0001);

        // Signed divide -7 / 2 with a D-stage user waiting the whole time.
        applyStimulus(1'b1, 2'b10, 32'hFFFF_FFF9, 32'd2, 2'b00, 1'b0, 1'b1);
        idleCycles(10, 1'b1);
        checkOutput("div_lo", lo, 32'hFFFF_FFFD);
        checkOutput("div_hi", hi, 32'hFFFF_FFFF);
        idleCycles(1, 1'b1);

        // Overflowing signed divide.
        applyStimulus(1'b1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 1'b0, 1'b0);
        idleCycles(10, 1'b0);
        checkOutput("divovf_lo", lo, 32'h8000_0000);
        checkOutput("divovf_hi", hi, 32'h0000_0000);

        // mthi, then divu by zero with an mtlo attempted during RUN.
        applyStimulus(1'b0, 2'b00, 32'h0000_1234, 32'd0, 2'b10, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b11, 32'd77, 32'd0, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b00, 32'h0000_0055, 32'd0, 2'b01, 1'b0, 1'b0);
        idleCycles(9, 1'b0);
        checkOutput("divz_hi", hi, 32'h0000_1234);
        checkOutput("divz_lo", lo, 32'h8000_0000);

        // Reset in the third busy cycle of a divide.
        applyStimulus(1'b1, 2'b10, 32'd1000, 32'd7, 2'b00, 1'b0, 1'b0);
        idleCycles(2, 1'b0);
        doReset(1'b0, 1'b1);
        idleCycles(12, 1'b0);
        checkOutput("postrst_hi", hi, 32'd0);
        checkOutput("postrst_lo", lo, 32'd0);

        // start + flush together, and a move under flush, are both dropped.
        applyStimulus(1'b0, 2'b00, 32'h0000_ABCD, 32'd0, 2'b11, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b00, 32'd5, 32'd6, 2'b00, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'b00, 32'h1111_1111, 32'd0, 2'b11, 1'b1, 1'b0);
        checkOutput("flush_busy", 32'(busy), 32'd0);
        checkOutput("flush_hi", hi, 32'h0000_ABCD);
        checkOutput("flush_lo", lo, 32'h0000_ABCD);

        // start wins over a simultaneous move; flush mid-RUN is harmless;
        // a second start during RUN is ignored.
        applyStimulus(1'b1, 2'b01, 32'd7, 32'd8, 2'b11, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 2'b00, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b00, 32'd9, 32'd9, 2'b11, 1'b0, 1'b1);
        idleCycles(3, 1'b0);
        checkOutput("prio_hi", hi, 32'd0);
        checkOutput("prio_lo", lo, 32'd56);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            st    = ($urandom_range(0, 3) == 0);
            op    = 2'($urandom_range(0, 3));
            a     = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 5);
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            mv    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            fl    = ($urandom_range(0, 7) == 0);
            use_d = 1'($urandom_range(0, 1));
            applyStimulus(st, op, a, b, mv, fl, use_d);
        end

        // Drain: bounded wait for the last operation to finish.
        for (int k = 0; k < 20 && run_left > 0; k++) idleCycles(1, 1'b0);
        checkOutput("drain_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL sb_pending: got %0d outstanding, expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
